// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed seven-segment scanner. A shadow register holds one
// active-low {a..g} pattern per digit. Each digit owns a slot of PRESCALE
// clocks. The first BLANK_CYCLES clocks of a slot keep every anode off, so
// segment data never ghosts onto the neighbouring digit. frame_done pulses
// once at the end of the last slot, which lets the producer pace its updates.
// Every output is registered, so there is no combinational path from any
// input to any output.
module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [7*NUM_DIGITS-1:0]   seg_in,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Scan position and the captured display image
    logic [CW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic [7*NUM_DIGITS-1:0]   r_shadow;

    // Registered outputs
    logic [6:0]                r_seg;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_frame;

    // Decode of the current (idx, cnt) position
    logic [6:0]                w_digits [NUM_DIGITS];
    logic [6:0]                w_digit;
    logic [NUM_DIGITS-1:0]     w_an_sel;
    logic                      w_blank;
    logic                      w_slot_end;
    logic                      w_last_digit;

    // Split the shadow into per-digit patterns and build the one-hot-low anode word
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_digits[gi] = r_shadow[7*gi +: 7];
            assign w_an_sel[gi] = (r_idx != IW'(gi));
        end
    endgenerate

    assign w_digit = w_digits[r_idx];

    // With zero blanking the comparison would be constant, so drop it entirely
    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (32'(r_cnt) < BLANK_CYCLES);
        end
    endgenerate

    assign w_slot_end   = (r_cnt == CW'(PRESCALE - 1));
    assign w_last_digit = (r_idx == IW'(NUM_DIGITS - 1));

    // Shadow capture, scan counters and registered output decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shadow <= '1;
            r_seg    <= 7'h7F;
            r_an     <= '1;
            r_frame  <= 1'b0;
        end else begin
            // Capture is independent of scanning; the decode below still sees
            // the old shadow, so a new image shows up one edge later.
            if (load) begin
                r_shadow <= seg_in;
            end

            if (enable) begin
                if (w_blank) begin
                    r_seg <= 7'h7F;
                    r_an  <= '1;
                end else begin
                    r_seg <= w_digit;
                    r_an  <= w_an_sel;
                end
                r_frame <= w_slot_end && w_last_digit;

                if (w_slot_end) begin
                    r_cnt <= '0;
                    r_idx <= w_last_digit ? '0 : r_idx + IW'(1);
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end else begin
                // Disabled: park at the start of digit 0 with the display dark
                r_cnt   <= '0;
                r_idx   <= '0;
                r_seg   <= 7'h7F;
                r_an    <= '1;
                r_frame <= 1'b0;
            end
        end
    end

    assign seg_out    = r_seg;
    assign an_out     = r_an;
    assign frame_done = r_frame;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances, one with a blanking gap of 2
// cycles and one with no gap, share the same stimulus. A time-based
// reference model predicts both sets of outputs.
module tb_seg_scan_driver;

    localparam int N = 4;
    localparam int P = 8;
    localparam int B = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          load;
    logic [27:0]   seg_in;

    logic [6:0]    seg_out;
    logic [3:0]    an_out;
    logic          frame_done;
    logic [6:0]    seg_out0;
    logic [3:0]    an_out0;
    logic          frame_done0;

    int tests = 0;
    int fails = 0;

    seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seg_in(seg_in),
        .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
    );

    seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .seg_in(seg_in),
        .seg_out(seg_out0), .an_out(an_out0), .frame_done(frame_done0)
    );

    always #5 clk = ~clk;

    // Reference model. t counts the edges since the scan (re)started.
    // Slot and position within the slot follow from plain division.
    int          t = 0;
    logic [27:0] m_shadow = '1;
    logic [6:0]  e_seg = 7'h7F;
    logic [6:0]  e_seg0 = 7'h7F;
    logic [3:0]  e_an = 4'hF;
    logic [3:0]  e_an0 = 4'hF;
    logic        e_fd = 1'b0;

    function automatic void decode(input int tt, input int blank, input logic [27:0] sh,
                                   output logic [6:0] s, output logic [3:0] a);
        int pos;
        int slot;
        pos  = tt % P;
        slot = (tt / P) % N;
        if (pos < blank) begin
            s = 7'h7F;
            a = 4'hF;
        end else begin
            s = sh[7*slot +: 7];
            a = 4'hF;
            a[slot] = 1'b0;
        end
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            m_shadow = '1;
            e_seg = 7'h7F; e_seg0 = 7'h7F;
            e_an = 4'hF;   e_an0 = 4'hF;
            e_fd = 1'b0;
        end else begin
            if (enable) begin
                decode(t, B, m_shadow, e_seg, e_an);
                decode(t, 0, m_shadow, e_seg0, e_an0);
                e_fd = ((t % (N*P)) == N*P - 1);
                t++;
            end else begin
                t = 0;
                e_seg = 7'h7F; e_seg0 = 7'h7F;
                e_an = 4'hF;   e_an0 = 4'hF;
                e_fd = 1'b0;
            end
            if (load) m_shadow = seg_in;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":seg"}, 32'(seg_out), 32'(e_seg));
        chk({tag, ":an"}, 32'(an_out), 32'(e_an));
        chk({tag, ":fd"}, 32'(frame_done), 32'(e_fd));
        chk({tag, ":seg0"}, 32'(seg_out0), 32'(e_seg0));
        chk({tag, ":an0"}, 32'(an_out0), 32'(e_an0));
        chk({tag, ":fd0"}, 32'(frame_done0), 32'(e_fd));
        chk({tag, ":onehot"}, 32'($countones(~an_out) <= 1), 32'd1);
        chk({tag, ":onehot0"}, 32'($countones(~an_out0) <= 1), 32'd1);
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Advance until the gapped instance shows the requested anode word
    task automatic wait_an(input logic [3:0] target, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step(tag);
            if (an_out === target) found = 1'b1;
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL %s_timeout observed=%h expected=%h", tag, an_out, target);
        end
    endtask

    task automatic reset_and_start(input string tag);
        reset = 1'b1; enable = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(tag);
            chk({tag, ":rst_seg"}, 32'(seg_out), 32'h7F);
            chk({tag, ":rst_an"}, 32'(an_out), 32'hF);
            chk({tag, ":rst_fd"}, 32'(frame_done), 32'h0);
        end
        reset = 1'b0; enable = 1'b1;
        step(tag); chk({tag, ":blank1"}, 32'(an_out), 32'hF);
        step(tag); chk({tag, ":blank2"}, 32'(an_out), 32'hF);
        step(tag);
        chk({tag, ":first_an"}, 32'(an_out), 32'hE);
        chk({tag, ":first_seg"}, 32'(seg_out), 32'h7F);
        $display("[TB] %s: reset and restart timing checked", tag);
    endtask

    initial begin
        int fd_count;
        reset = 1'b1; enable = 1'b0; load = 1'b0; seg_in = '0;

        // 1: reset, then release with enable high
        reset_and_start("t1");

        // 2: load a pattern and scan two full frames
        seg_in = {7'h7E, 7'h7F, 7'h4F, 7'h01};
        load = 1'b1;
        step("t2_load");
        load = 1'b0;
        seg_in = '0;
        fd_count = 0;
        for (int i = 0; i < 64; i++) begin
            step("t2_scan");
            if (frame_done) fd_count++;
        end
        chk("t2_frames", 32'(fd_count), 32'd2);
        $display("[TB] t2: two frames scanned with pattern 7E/7F/4F/01");

        // 3: seg_in changes with load low are ignored; a load in digit 1 shows one edge later
        seg_in = {4{7'h2A}};
        for (int i = 0; i < 16; i++) step("t3_noload");
        wait_an(4'b1101, "t3_wait");
        seg_in = {7'h7E, 7'h7F, 7'h12, 7'h01};
        load = 1'b1;
        step("t3_load");
        chk("t3_old_seg", 32'(seg_out), 32'h4F);
        load = 1'b0;
        step("t3_after");
        chk("t3_new_seg", 32'(seg_out), 32'h12);
        $display("[TB] t3: load latency checked");

        // 4: disable during digit 2, then re-enable
        wait_an(4'b1011, "t4_wait");
        enable = 1'b0;
        step("t4_dis");
        chk("t4_dis_an", 32'(an_out), 32'hF);
        chk("t4_dis_seg", 32'(seg_out), 32'h7F);
        chk("t4_dis_fd", 32'(frame_done), 32'h0);
        step("t4_dis"); step("t4_dis");
        enable = 1'b1;
        step("t4_re"); chk("t4_re_blank1", 32'(an_out), 32'hF);
        step("t4_re"); chk("t4_re_blank2", 32'(an_out), 32'hF);
        step("t4_re"); chk("t4_re_an", 32'(an_out), 32'hE);
        chk("t4_re_seg", 32'(seg_out), 32'h01);
        $display("[TB] t4: disable and restart checked");

        // 5: reset during digit 2 clears the shadow and repeats the startup timing
        wait_an(4'b1011, "t5_wait");
        reset_and_start("t5");

        // Random traffic on both instances; 6 is covered by the gapless instance
        for (int i = 0; i < 3000; i++) begin
            seg_in = {$urandom, $urandom} & 28'hFFFFFFF;
            load   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            reset  = ($urandom_range(0, 499) == 0);
            step("rand");
            if (i % 500 == 499) $display("[TB] random batch %0d done", i / 500);
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
